// File: rtl/load_store_unit.sv
// Load/store unit: turns one 8/16/32-bit core request into a sequence of
// single-byte bus transfers, then returns a one-cycle response.
module load_store_unit #(
    parameter int ENDIANNESS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    if (ENDIANNESS != 0 && ENDIANNESS != 1) begin : g_bad_endianness
        $error("load_store_unit: ENDIANNESS must be 0 (big) or 1 (little)");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        accept;
    logic        req_legal;
    logic [1:0]  last_idx;
    logic [1:0]  lane;
    logic        xfer_done;
    logic        last_xfer;
    logic [31:0] acc_upd;
    logic [31:0] load_ext;

    // Handshake: a request is taken on an edge where req_valid && req_ready;
    // a byte moves on an edge where mem_valid && mem_ready. Nothing else counts.
    always_comb begin
        accept    = req_valid && (state_q == S_IDLE);
        req_legal = req_write ? (req_size inside {3'b000, 3'b001, 3'b010})
                              : !(req_size inside {3'b011, 3'b110, 3'b111});
        last_idx  = size_q[1] ? 2'd3 : (size_q[0] ? 2'd1 : 2'd0);
        lane      = (ENDIANNESS == 0) ? 2'(last_idx - k_q) : k_q;
        xfer_done = (state_q == S_BUS) && mem_ready;
        last_xfer = xfer_done && (k_q == last_idx);
        acc_upd   = acc_q;
        acc_upd[{lane, 3'b000} +: 8] = mem_rdata;
        case (size_q[1:0])
            2'b00:   load_ext = {{24{~size_q[2] & acc_upd[7]}}, acc_upd[7:0]};
            2'b01:   load_ext = {{16{~size_q[2] & acc_upd[15]}}, acc_upd[15:0]};
            default: load_ext = acc_upd;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = req_legal ? S_BUS : S_RESP;
            S_BUS:  if (last_xfer) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        k_d     = k_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        error_d = error_q;
        if (accept) begin
            write_d = req_write;
            size_d  = req_size;
            addr_d  = req_address;
            wdata_d = req_wdata;
            k_d     = 2'd0;
            acc_d   = 32'd0;
            if (!req_legal) begin
                error_d = 1'b1;
                rdata_d = 32'd0;
            end
        end
        if (xfer_done) begin
            k_d   = 2'(k_q + 2'd1);
            acc_d = acc_upd;
            // Result is registered on the final byte so it is ready in RESP.
            if (last_xfer) begin
                error_d = 1'b0;
                rdata_d = write_q ? 32'd0 : load_ext;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k_q     <= 2'd0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            acc_q   <= 32'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            k_q     <= k_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Bus outputs depend only on registered state, so they stay put while stalled.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        resp_valid  = (state_q == S_RESP);
        resp_rdata  = rdata_q;
        resp_error  = error_q;
        mem_valid   = (state_q == S_BUS);
        mem_write   = (state_q == S_BUS) && write_q;
        mem_address = (state_q == S_BUS) ? (addr_q + {30'd0, k_q}) : 32'd0;
        mem_wdata   = ((state_q == S_BUS) && write_q) ? wdata_q[{lane, 3'b000} +: 8] : 8'h00;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ENDIANNESS, default 1, byte order: 0 = big endian, 1 = little endian; any other value SHALL stop elaboration or simulation with an error.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW.
REQ-008 req_address  input  32  byte address of the first byte.
REQ-009 req_wdata  input  32  store data (low bits used for SB/SH).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended to 32 bits.
REQ-012 resp_error  output  1  illegal req_size; valid only with resp_valid.
REQ-013 mem_valid  output  1  byte-bus request.
REQ-014 mem_ready  input  1  byte-bus acknowledge.
REQ-015 mem_write  output  1  byte-bus write strobe.
REQ-016 mem_address  output  32  byte-bus address.
REQ-017 mem_wdata  output  8  byte-bus write data.
REQ-018 mem_rdata  input  8  byte-bus read data; valid in any cycle where mem_valid=1, mem_write=0 and mem_ready=1.

Function
REQ-019 States SHALL be IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Request acceptance: a request SHALL be accepted when req_valid=1 and req_ready=1 at a rising edge, and req_write, req_size, req_address and req_wdata SHALL be latched at that edge.
REQ-021 Legal request: the unit SHALL go IDLE->BUS; byte count N SHALL be 1 for size x00, 2 for x01 and 4 for 010; byte counter k SHALL reset to 0.
REQ-022 Illegal size: stores with size not in {000,001,010} and loads with size in {011,110,111} SHALL go IDLE->RESP with resp_error=1 and resp_rdata=0, and no bus cycle SHALL occur.
REQ-023 BUS signals: mem_valid SHALL be 1; mem_address SHALL be latched address+k, computed modulo 2^32 so that 0xFFFFFFFF+1 wraps to 0; mem_write SHALL equal the latched req_write.
REQ-024 Bus stability: mem_address, mem_write and mem_wdata SHALL be held stable while mem_valid=1 and mem_ready=0.
REQ-025 Little-endian byte mapping (ENDIANNESS=1): byte k SHALL carry data bits [8k+7:8k].
REQ-026 Big-endian byte mapping (ENDIANNESS=0): byte k SHALL carry data bits [8(N-1-k)+7:8(N-1-k)].
REQ-027 The same byte mapping SHALL be used to place each returned load byte.
REQ-028 Handshake: a byte transfer SHALL complete at an edge where mem_valid=1 and mem_ready=1; on completion k SHALL increment.
REQ-029 Back-to-back transfers: the next byte SHALL be presented in the following cycle without dropping mem_valid.
REQ-030 After byte N-1 completes, the unit SHALL go BUS->RESP.
REQ-031 RESP SHALL last exactly one cycle with resp_valid=1, then go RESP->IDLE.
REQ-032 Load extension: LB and LH SHALL sign-extend from bit 7 and bit 15 respectively; LBU and LHU SHALL zero-extend.
REQ-033 Store response: resp_rdata SHALL be 0.
REQ-034 resp_rdata SHALL hold its value until the next RESP.
REQ-035 Latency with mem_ready tied to 1, request accepted at edge T: bytes SHALL complete at edges T+1..T+N, and resp_valid SHALL be high in cycle T+N+1; an illegal request SHALL give resp_valid in cycle T+1.
REQ-036 Unbounded stall: mem_ready held at 0 indefinitely SHALL hold the unit in BUS with no timeout.
REQ-037 While not in BUS, mem_valid SHALL be 0, and mem_write and mem_wdata SHALL be driven 0.
REQ-038 Sampling: req_valid SHALL be ignored outside IDLE, and mem_ready SHALL be ignored when mem_valid=0.

Reset
REQ-039 Reset assertion SHALL, asynchronously and at any time (including mid-BUS), force IDLE, k=0, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_valid=0, mem_write=0, mem_address=0 and mem_wdata=0.
REQ-040 A transfer in progress at reset SHALL be abandoned with no response.
REQ-041 The first request SHALL be accepted at the first rising edge after reset deassertion at which req_valid=1.

Verification
REQ-042 ENDIANNESS=1, SW addr 0x10 data 0xA1B2C3D4, mem_ready=1 -> writes 0x10<-D4, 0x11<-C3, 0x12<-B2, 0x13<-A1 on 4 consecutive cycles; resp_valid 5 cycles after accept.
REQ-043 ENDIANNESS=0, LH addr 0x20, bus returns 0x80 then 0x01 -> resp_rdata=0xFFFF8001; LHU under the same stimulus -> 0x00008001.
REQ-044 LW addr 0xFFFFFFFE -> mem_address sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-045 LB with mem_ready held 0 for 3 cycles, bus byte 0x7F -> mem_valid high 4 cycles with stable address; resp_rdata=0x0000007F.
REQ-046 Store with size 011 -> resp_valid and resp_error both 1 in the next cycle; mem_valid never asserted.
REQ-047 Reset asserted during byte 2 of an LW -> mem_valid=0 immediately; no resp_valid; a following LBU completes normally.
